// File: rtl/alarm_slot_scheduler.sv
// Multi-slot BCD alarm scheduler: scans slots on each minute change, grants the buzzer to the lowest matching slot.
// Optional snooze sequencing is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_slot_scheduler #(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [31:0] RING_CYCLES = 32'd600_000_000,
  parameter int          SNOOZE_MIN  = 5
) (
  input  logic                         pclk_i,
  input  logic                         preset_i,
  input  logic                         cfg_we_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot_i,
  input  logic [15:0]                  cfg_time_i,
  input  logic                         cfg_en_i,
  input  logic [15:0]                  time_now_i,
  input  logic                         off_i,
  input  logic                         snooze_i,
  output logic                         ring_o,
  output logic [$clog2(NUM_SLOTS)-1:0] ring_slot_o,
  output logic                         busy_o,
  output logic [NUM_SLOTS-1:0]         slot_en_o
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  if (NUM_SLOTS < 2 || RING_CYCLES < 2 || SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_param_check
    $error("alarm_slot_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RING
`ifdef ALARM_SNOOZE_EN
    , S_SNOOZE
`endif
  } state_t;

  logic [15:0]          slot_time_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en_q;
  logic [15:0]          prev_now_q;
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          scan_time_q, scan_time_d;
  logic [31:0]          ring_cnt_q, ring_cnt_d;
  logic [IDX_W-1:0]     ring_slot_q, ring_slot_d;
  logic                 ring_q, busy_q;
  logic                 min_edge, slot_hit, disable_hit;

`ifdef ALARM_SNOOZE_EN
  logic [3:0]           snz_cnt_q, snz_cnt_d;
`else
  logic                 unused_snooze;
  assign unused_snooze = snooze_i;
`endif

  // NOTE: the slot array is reset as well, so a reset wipes every programmed alarm.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_time_q[i] <= 16'h0000;
      slot_en_q  <= '0;
      prev_now_q <= 16'h0000;
    end else begin
      if (cfg_we_i) begin
        slot_time_q[cfg_slot_i] <= cfg_time_i;
        slot_en_q[cfg_slot_i]   <= cfg_en_i;
      end
      prev_now_q <= time_now_i;
    end
  end

  assign min_edge    = (time_now_i != prev_now_q);
  assign slot_hit    = slot_en_q[idx_q] && (slot_time_q[idx_q] == scan_time_q);
  assign disable_hit = cfg_we_i && !cfg_en_i && (cfg_slot_i == ring_slot_q);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scan_time_d = scan_time_q;
    ring_cnt_d  = ring_cnt_q;
    ring_slot_d = ring_slot_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d   = snz_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (min_edge) begin
          state_d     = S_SCAN;
          idx_d       = '0;
          scan_time_d = time_now_i;
        end
      end
      S_SCAN: begin
        if (min_edge) begin
          idx_d       = '0;
          scan_time_d = time_now_i;
        end else if (slot_hit) begin
          state_d     = S_RING;
          ring_slot_d = idx_q;
          ring_cnt_d  = RING_CYCLES;
        end else if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RING: begin
        // Minute edges are deliberately ignored while ringing.
        if (off_i || disable_hit) begin
          state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_i) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = 4'(SNOOZE_MIN);
`endif
        end else if (ring_cnt_q == 32'd1) begin
          state_d = S_IDLE;
        end else begin
          ring_cnt_d = ring_cnt_q - 32'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (off_i || disable_hit) begin
          state_d = S_IDLE;
        end else if (min_edge) begin
          if (snz_cnt_q == 4'd1) begin
            state_d    = S_RING;
            ring_cnt_d = RING_CYCLES;
          end
          snz_cnt_d = snz_cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      scan_time_q <= 16'h0000;
      ring_cnt_q  <= 32'd0;
      ring_slot_q <= '0;
      ring_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scan_time_q <= scan_time_d;
      ring_cnt_q  <= ring_cnt_d;
      ring_slot_q <= ring_slot_d;
      ring_q      <= (state_d == S_RING);
      busy_q      <= (state_d == S_SCAN);
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q   <= snz_cnt_d;
`endif
    end
  end

  assign ring_o      = ring_q;
  assign ring_slot_o = ring_slot_q;
  assign busy_o      = busy_q;
  assign slot_en_o   = slot_en_q;
endmodule

// File: tb/tb_alarm_slot_scheduler.sv
// Directed self-checking bench for alarm_slot_scheduler (NUM_SLOTS=4, RING_CYCLES=8, SNOOZE_MIN=2).
module tb_alarm_slot_scheduler;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        preset, cfg_we, cfg_en, off, snooze;
  logic [1:0]  cfg_slot;
  logic [15:0] cfg_time, time_now;
  logic        ring, busy;
  logic [1:0]  ring_slot;
  logic [NS-1:0] slot_en;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n;
  logic        saw_ring;

  alarm_slot_scheduler #(.NUM_SLOTS(NS), .RING_CYCLES(32'd8), .SNOOZE_MIN(2)) dut (
    .pclk_i(clk), .preset_i(preset), .cfg_we_i(cfg_we), .cfg_slot_i(cfg_slot),
    .cfg_time_i(cfg_time), .cfg_en_i(cfg_en), .time_now_i(time_now), .off_i(off),
    .snooze_i(snooze), .ring_o(ring), .ring_slot_o(ring_slot), .busy_o(busy),
    .slot_en_o(slot_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] t, input logic e);
    cfg_we = 1'b1; cfg_slot = s; cfg_time = t; cfg_en = e;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_off();
    off = 1'b1;
    tick();
    off = 1'b0;
  endtask

  task automatic ring_len(output int len);
    len = 0;
    while (ring && len < 20) begin
      len++;
      tick();
    end
  endtask

  task automatic watch_ring(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ring) seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset = 1'b1; cfg_we = 1'b0; cfg_en = 1'b0; cfg_slot = '0; cfg_time = '0;
    time_now = 16'h0000; off = 1'b0; snooze = 1'b0;
    tick(2);
    preset = 1'b0;
    check("rst_ring", ring, 0);
    check("rst_slot", ring_slot, 0);
    check("rst_busy", busy, 0);
    check("rst_en", slot_en, 0);

    // Basic match on slot 2: ring at t+4, held for 8 cycles
    wr(2, 16'h0730, 1'b1);
    check("en_after_wr", slot_en, 4'b0100);
    time_now = 16'h0729;
    tick(6);
    check("idle_busy", busy, 0);
    time_now = 16'h0730;
    tick();
    check("t1_busy", busy, 1);
    tick(2);
    check("t3_ring", ring, 0);
    tick();
    check("t4_ring", ring, 1);
    check("t4_slot", ring_slot, 2);
    check("t4_busy", busy, 0);
    ring_len(n);
    check("ring_len", n, 8);
    check("slot_hold", ring_slot, 2);

    // Two slots match: lowest index wins, off ends ring next cycle
    wr(1, 16'h1200, 1'b1);
    wr(3, 16'h1200, 1'b1);
    time_now = 16'h1200;
    tick(3);
    check("prio_ring", ring, 1);
    check("prio_slot", ring_slot, 1);
    pulse_off();
    check("off_ring", ring, 0);
    watch_ring(10, saw_ring);
    check("slot3_silent", saw_ring, 0);

    // off and snooze together: off wins, no re-ring on later edges
    time_now = 16'h0730;
    tick(4);
    check("os_ring", ring, 1);
    off = 1'b1; snooze = 1'b1;
    tick();
    off = 1'b0; snooze = 1'b0;
    check("os_off", ring, 0);
    saw_ring = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      time_now = 16'h0730 + 16'(m);
      for (int i = 0; i < 6; i++) begin
        tick();
        if (ring) saw_ring = 1'b1;
      end
    end
    check("os_no_rering", saw_ring, 0);

    // Snooze
    time_now = 16'h0730;
    tick(4);
    check("snz_ring", ring, 1);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    check("snz_quiet", ring, 0);
    time_now = 16'h0731;
    tick(3);
    check("snz_edge1", ring, 0);
    time_now = 16'h0732;
    tick();
    check("snz_edge2", ring, 1);
    check("snz_slot", ring_slot, 2);
    ring_len(n);
    check("snz_len", n, 8);
`else
    check("snz_ignored", ring, 1);
    ring_len(n);
    check("snz_remain", n, 7);
`endif

    // Disabled slot with matching time: scan only, busy 4 cycles
    wr(0, 16'h0800, 1'b0);
    check("en_mask", slot_en, 4'b1110);
    time_now = 16'h0800;
    tick();
    check("dis_busy", busy, 1);
    n = 0;
    saw_ring = 1'b0;
    while (busy && n < 20) begin
      n++;
      tick();
      if (ring) saw_ring = 1'b1;
    end
    check("dis_busy_len", n, 4);
    check("dis_noring", saw_ring, 0);

    // Disable-write to ringing slot
    time_now = 16'h0730;
    tick(4);
    check("dw_ring", ring, 1);
    tick(2);
    wr(2, 16'h0730, 1'b0);
    check("dw_off", ring, 0);
    check("dw_en", slot_en, 4'b1010);

    // Write and edge in the same cycle, match on slot 0 at t+2
    time_now = 16'h0900;
    wr(0, 16'h0900, 1'b1);
    tick();
    check("wr_edge_ring", ring, 1);
    check("wr_edge_slot", ring_slot, 0);
    pulse_off();

    // Reset mid-ring, then 0000->0001 edge must not ring
    wr(2, 16'h0730, 1'b1);
    time_now = 16'h0731;
    tick(6);
    time_now = 16'h0730;
    tick(4);
    check("pr_ring", ring, 1);
    check("pr_slot", ring_slot, 2);
    tick(2);
    preset = 1'b1;
    time_now = 16'h0000;
    tick();
    preset = 1'b0;
    check("pr_ring0", ring, 0);
    check("pr_slot0", ring_slot, 0);
    check("pr_busy0", busy, 0);
    check("pr_en0", slot_en, 0);
    time_now = 16'h0001;
    tick();
    check("pr_scan", busy, 1);
    watch_ring(8, saw_ring);
    check("pr_noring", saw_ring, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
